// File: rtl/simon_control.sv
`default_nettype none
// ============================================================================
// Module   : simon_control
// Brief    : Control FSM for the Simon game: pattern entry, paced playback,
//            player repeat with checking, and a terminal DONE replay loop.
// Revision : 1.0
// ============================================================================
module simon_control #(
  parameter int PLAY_TICKS = 4,
  parameter int MAX_LEN    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic       seq_remain,
  input  logic       valid_repeat,
  input  logic       valid_input,
  output logic       clear_i,
  output logic       increment_i,
  output logic       increment_n,
  output logic       write_pattern,
  output logic       input_led_pattern,
  output logic [2:0] mode_leds,
  output logic       won,
  output logic [6:0] seq_len
);

  typedef enum logic [1:0] {
    S_INPUT    = 2'd0,
    S_PLAYBACK = 2'd1,
    S_REPEAT   = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [7:0] c_LAST_TICK = 8'(PLAY_TICKS - 1);
  localparam logic [6:0] c_MAX_LEN   = 7'(MAX_LEN);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_dwell;
  logic [7:0] w_dwell_nxt;
  logic [6:0] r_len;
  logic [6:0] w_len_nxt;
  logic       r_won;
  logic       w_won_nxt;
  logic       w_last_tick;

  assign w_last_tick = (r_dwell == c_LAST_TICK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INPUT;
      r_dwell <= 8'd0;
      r_len   <= 7'd0;
      r_won   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dwell <= w_dwell_nxt;
      r_len   <= w_len_nxt;
      r_won   <= w_won_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_dwell_nxt   = r_dwell;
    w_len_nxt     = r_len;
    w_won_nxt     = r_won;
    clear_i       = 1'b0;
    increment_i   = 1'b0;
    increment_n   = 1'b0;
    write_pattern = 1'b0;

    case (r_state)
      S_INPUT: begin
        if (enter && valid_input) begin
          write_pattern = 1'b1;
          increment_n   = 1'b1;
          clear_i       = 1'b1;
          w_len_nxt     = r_len + 7'd1;
          w_dwell_nxt   = 8'd0;
          w_state_nxt   = S_PLAYBACK;
        end
      end

      // PLAYBACK and DONE share the dwell pacing; only the end-of-sequence
      // action differs (hand over to REPEAT vs. wrap to element 0).
      S_PLAYBACK, S_DONE: begin
        if (w_last_tick) begin
          w_dwell_nxt = 8'd0;
          if (seq_remain) begin
            increment_i = 1'b1;
          end else begin
            clear_i = 1'b1;
            if (r_state == S_PLAYBACK) begin
              w_state_nxt = S_REPEAT;
            end
          end
        end else begin
          w_dwell_nxt = r_dwell + 8'd1;
        end
      end

      S_REPEAT: begin
        if (enter) begin
          if (!valid_repeat) begin
            clear_i     = 1'b1;
            w_won_nxt   = 1'b0;
            w_dwell_nxt = 8'd0;
            w_state_nxt = S_DONE;
          end else if (seq_remain) begin
            increment_i = 1'b1;
          end else if (r_len < c_MAX_LEN) begin
            clear_i     = 1'b1;
            w_state_nxt = S_INPUT;
          end else begin
            clear_i     = 1'b1;
            w_won_nxt   = 1'b1;
            w_dwell_nxt = 8'd0;
            w_state_nxt = S_DONE;
          end
        end
      end

      default: w_state_nxt = S_INPUT;
    endcase

    if (rst) begin
      clear_i       = 1'b0;
      increment_i   = 1'b0;
      increment_n   = 1'b0;
      write_pattern = 1'b0;
    end
  end

  always_comb begin
    input_led_pattern = 1'b0;
    mode_leds         = 3'b001;
    case (r_state)
      S_INPUT: begin
        input_led_pattern = 1'b1;
        mode_leds         = 3'b001;
      end
      S_PLAYBACK: mode_leds = 3'b010;
      S_REPEAT: begin
        input_led_pattern = 1'b1;
        mode_leds         = 3'b100;
      end
      S_DONE:   mode_leds = 3'b111;
      default:  mode_leds = 3'b001;
    endcase
  end

  assign won     = (r_state == S_DONE) && r_won;
  assign seq_len = r_len;

endmodule
`default_nettype wire

// File: doc/simon_control.md
# simon_control

Control FSM for the Simon game, sitting beside the Simon datapath. It consumes the datapath status flags (`seq_remain`, `valid_repeat`, `valid_input`) and a one-cycle user `enter` strobe. It produces the datapath control strobes and the mode LEDs. It sequences four phases: pattern entry, paced playback of the stored sequence, player repeat with checking, and a terminal DONE loop (loss or win).

## Interface
Parameters:
- `PLAY_TICKS`, default 4: cycles each element is shown during PLAYBACK/DONE replay; legal range 1..255.
- `MAX_LEN`, default 64: sequence length that counts as a win; must not exceed datapath memory depth (64).

Ports:
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `enter` in 1: user commit strobe, one cycle per press, already debounced and synchronized.
- `seq_remain` in 1: datapath flag, i < n-1.
- `valid_repeat` in 1: datapath flag, memory[i] == pattern switches.
- `valid_input` in 1: datapath flag, pattern is legal for the current level.
- `clear_i` out 1: datapath i := 0 at this edge.
- `increment_i` out 1: datapath i := i+1 at this edge.
- `increment_n` out 1: datapath n := n+1 at this edge.
- `write_pattern` out 1: write switches to memory[n] at this edge.
- `input_led_pattern` out 1: 1 = LEDs mirror switches; 0 = LEDs show memory[i].
- `mode_leds` out 3: INPUT 001, PLAYBACK 010, REPEAT 100, DONE 111.
- `won` out 1: high in DONE only if DONE was entered by completing `MAX_LEN`.
- `seq_len` out 7: number of committed elements (0..MAX_LEN).

## Operation
- Registers: `state` (INPUT, PLAYBACK, REPEAT, DONE), `dwell` (8-bit), `len` (7-bit), `won_r`.
- Strobe outputs are combinational from state, inputs and `dwell`, and are forced 0 while `rst`=1. `clear_i` and `increment_i` are never asserted in the same cycle.
- INPUT (`input_led_pattern`=1):
  - `enter` && `valid_input`: assert `write_pattern`, `increment_n`, `clear_i`; `len`++; `dwell`:=0; go to PLAYBACK.
  - `enter` && !`valid_input`: ignored, no strobes, stay.
- PLAYBACK (`input_led_pattern`=0):
  - `dwell` counts 0..PLAY_TICKS-1.
  - At `dwell`==PLAY_TICKS-1:
    - If `seq_remain`: assert `increment_i`, `dwell`:=0.
    - Else: assert `clear_i`, go to REPEAT.
  - `enter` is ignored.
- REPEAT (`input_led_pattern`=1), on `enter`:
  - !`valid_repeat`: assert `clear_i`; `won_r`:=0; `dwell`:=0; go to DONE.
  - `valid_repeat` && `seq_remain`: assert `increment_i`; stay.
  - `valid_repeat` && !`seq_remain` && `len`<MAX_LEN: assert `clear_i`; go to INPUT.
  - `valid_repeat` && !`seq_remain` && `len`==MAX_LEN: assert `clear_i`; `won_r`:=1; go to DONE.
- DONE (`input_led_pattern`=0):
  - Replays the sequence endlessly with the same dwell pacing as PLAYBACK.
  - At the last element, assert `clear_i` instead of `increment_i` (wraps to element 0).
  - `enter` is ignored. Exit only via `rst`.
- `len` never exceeds MAX_LEN. INPUT is never re-entered at `len`==MAX_LEN, so datapath `n` cannot wrap.

## Timing
- Reset: after the first posedge with `rst`=1:
  - state = INPUT, `dwell` = 0, `len` = 0, `won_r` = 0.
  - `mode_leds`=001, `input_led_pattern`=1, `won`=0, `seq_len`=0, all strobes 0.
- `rst` wins over `enter` in the same cycle. `rst` mid-PLAYBACK, REPEAT or DONE returns to INPUT on that edge with no strobe emitted.
- Strobes are Mealy and act on the same edge as the state transition. The datapath sees updated i/n one cycle later, so flags sampled in the next state reflect the update.
- Sequence length L: PLAYBACK lasts exactly L*PLAY_TICKS cycles. REPEAT's first cycle follows immediately.
- `enter` in the cycle of entering a state is evaluated by the new state only from the following cycle.
- `mode_leds`, `won` and `seq_len` are registered-state decodes with no combinational input path.

## Test plan
- Reset, then `enter` with `valid_input`=1 → one cycle of `write_pattern`=`increment_n`=`clear_i`=1, `seq_len`=1, `mode_leds`=010; with PLAY_TICKS=4 and `seq_remain`=0, `mode_leds`=100 after 4 cycles.
- INPUT, `enter` with `valid_input`=0 → no strobes, `mode_leds` stays 001, `seq_len` stays 0.
- L=3 playback (`seq_remain` 1,1,0) → `increment_i` pulses at cycles 4 and 8, `clear_i` at cycle 12, then REPEAT.
- REPEAT, `enter` with `valid_repeat`=0 → `clear_i` pulse, `mode_leds`=111, `won`=0; further `enter` pulses ignored; DONE wraps i via `clear_i` every L*PLAY_TICKS cycles.
- MAX_LEN=2: two full correct rounds → DONE with `won`=1, `seq_len`=2.
- `rst` asserted mid-PLAYBACK together with `enter` → next cycle `mode_leds`=001, `seq_len`=0, all strobes 0.
